// File: rtl/nf_sume_10g_pkg.sv
// rtl/nf_sume_10g_pkg.sv - shared types and defaults for the 10G RX bring-up sequencer
package nf_sume_10g_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_USERRDY,
    ST_WAIT_LOCK,
    ST_READY,
    ST_RETRY,
    ST_FAIL
  } rx_seq_state_e;

  localparam int DEF_SYNC_STAGES       = 4;
  localparam int DEF_RESETDONE_TIMEOUT = 32768;
  localparam int DEF_LOCK_TIMEOUT      = 65535;
  localparam int DEF_RETRY_PULSE       = 8;
  localparam int DEF_MAX_RETRIES       = 3;

  // Consecutive block_lock-low cycles in READY treated as a real loss of lock
  localparam int LOL_FILTER_LEN = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nf_sume_10g_sync_bit.sv
// rtl/nf_sume_10g_sync_bit.sv - N-stage single-bit synchronizer with optional async clear-on-low or set-on-high
module nf_sume_10g_sync_bit #(
  parameter int STAGES      = 4,
  parameter bit CLR_ON_LOW  = 1'b0,
  parameter bit SET_ON_HIGH = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_ff;
  logic clr;
  logic set;
  logic shift_in;

  // In the async variants d only drives the async pin; the chain shifts in the
  // released level so the input never reaches a synchronous data path.
  generate
    if (CLR_ON_LOW) begin : g_clr
      assign clr      = rst | ~d;
      assign set      = 1'b0;
      assign shift_in = 1'b1;
    end else if (SET_ON_HIGH) begin : g_set
      assign clr      = rst;
      assign set      = d;
      assign shift_in = 1'b0;
    end else begin : g_plain
      assign clr      = rst;
      assign set      = 1'b0;
      assign shift_in = d;
    end
  endgenerate

  always_ff @(posedge clk or posedge clr or posedge set) begin
    if (clr) begin
      sync_ff <= '0;
    end else if (set) begin
      sync_ff <= '1;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], shift_in};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/nf_sume_10g_rx_userrdy_seq.sv
// rtl/nf_sume_10g_rx_userrdy_seq.sv - RX user-ready sequencer with bounded GT RX reset retries; NF_SUME_RX_LOCK_MONITOR_EN adds loss-of-lock retry in READY
module nf_sume_10g_rx_userrdy_seq
  import nf_sume_10g_pkg::*;
#(
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int RESETDONE_TIMEOUT = DEF_RESETDONE_TIMEOUT,
  parameter int LOCK_TIMEOUT      = DEF_LOCK_TIMEOUT,
  parameter int RETRY_PULSE       = DEF_RETRY_PULSE,
  parameter int MAX_RETRIES       = DEF_MAX_RETRIES
) (
  input  logic                               txusrclk2,
  input  logic                               gttxreset,
  input  logic                               qplllock,
  input  logic                               gtrxreset,
  input  logic                               rx_resetdone,
  input  logic                               block_lock,
  output logic                               rxuserrdy,
  output logic                               gtrxreset_req,
  output logic                               rx_ready,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic                               rx_fail
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int TW = $clog2(max_int(RESETDONE_TIMEOUT, LOCK_TIMEOUT) + 1);
  localparam int PW = $clog2(RETRY_PULSE + 1);

  localparam logic [TW-1:0] T_RESETDONE = TW'(RESETDONE_TIMEOUT);
  localparam logic [TW-1:0] T_LOCK      = TW'(LOCK_TIMEOUT);
  localparam logic [PW-1:0] PULSE_LOAD  = PW'(RETRY_PULSE - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  logic qplllock_s;
  logic gtrxreset_s;
  logic rx_resetdone_s;
  logic block_lock_s;

  nf_sume_10g_sync_bit #(.STAGES(SYNC_STAGES), .CLR_ON_LOW(1'b1), .SET_ON_HIGH(1'b0)) u_sync_qplllock (
    .clk (txusrclk2),
    .rst (gttxreset),
    .d   (qplllock),
    .q   (qplllock_s)
  );

  nf_sume_10g_sync_bit #(.STAGES(SYNC_STAGES), .CLR_ON_LOW(1'b0), .SET_ON_HIGH(1'b1)) u_sync_gtrxreset (
    .clk (txusrclk2),
    .rst (gttxreset),
    .d   (gtrxreset),
    .q   (gtrxreset_s)
  );

  nf_sume_10g_sync_bit #(.STAGES(SYNC_STAGES), .CLR_ON_LOW(1'b0), .SET_ON_HIGH(1'b0)) u_sync_resetdone (
    .clk (txusrclk2),
    .rst (gttxreset),
    .d   (rx_resetdone),
    .q   (rx_resetdone_s)
  );

  nf_sume_10g_sync_bit #(.STAGES(SYNC_STAGES), .CLR_ON_LOW(1'b0), .SET_ON_HIGH(1'b0)) u_sync_block_lock (
    .clk (txusrclk2),
    .rst (gttxreset),
    .d   (block_lock),
    .q   (block_lock_s)
  );

  rx_seq_state_e state;
  logic [TW-1:0] timer;
  logic [PW-1:0] pulse_cnt;
  logic          abort;
  logic          retry_ok;
  logic          timer_zero;
`ifdef NF_SUME_RX_LOCK_MONITOR_EN
  logic [$clog2(LOL_FILTER_LEN)-1:0] lol_cnt;
`endif

  assign abort      = !qplllock_s || gtrxreset_s;
  assign retry_ok   = (retry_cnt != RETRY_MAX);
  assign timer_zero = (timer == '0);

  // An exhausted budget still passes through RETRY for one cycle, with no
  // request pulse; RETRY tells the two cases apart by gtrxreset_req.
  always_ff @(posedge txusrclk2 or posedge gttxreset) begin
    if (gttxreset) begin
      state         <= ST_IDLE;
      timer         <= '0;
      pulse_cnt     <= '0;
      retry_cnt     <= '0;
      rxuserrdy     <= 1'b0;
      gtrxreset_req <= 1'b0;
      rx_ready      <= 1'b0;
      rx_fail       <= 1'b0;
`ifdef NF_SUME_RX_LOCK_MONITOR_EN
      lol_cnt       <= '0;
`endif
    end else begin
`ifdef NF_SUME_RX_LOCK_MONITOR_EN
      if (state != ST_READY) lol_cnt <= '0;
`endif
      case (state)
        ST_IDLE: begin
          if (qplllock_s && !gtrxreset_s) begin
            state     <= ST_USERRDY;
            timer     <= T_RESETDONE;
            rxuserrdy <= 1'b1;
          end
        end

        ST_USERRDY: begin
          if (abort) begin
            state     <= ST_IDLE;
            rxuserrdy <= 1'b0;
          end else if (rx_resetdone_s) begin
            state <= ST_WAIT_LOCK;
            timer <= T_LOCK;
          end else if (timer_zero) begin
            state         <= ST_RETRY;
            rxuserrdy     <= 1'b0;
            gtrxreset_req <= retry_ok;
            pulse_cnt     <= PULSE_LOAD;
            if (retry_ok) retry_cnt <= retry_cnt + 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (abort) begin
            state     <= ST_IDLE;
            rxuserrdy <= 1'b0;
          end else if (block_lock_s) begin
            state     <= ST_READY;
            rx_ready  <= 1'b1;
            retry_cnt <= '0;
          end else if (timer_zero) begin
            state         <= ST_RETRY;
            rxuserrdy     <= 1'b0;
            gtrxreset_req <= retry_ok;
            pulse_cnt     <= PULSE_LOAD;
            if (retry_ok) retry_cnt <= retry_cnt + 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        ST_READY: begin
          if (abort) begin
            state     <= ST_IDLE;
            rxuserrdy <= 1'b0;
            rx_ready  <= 1'b0;
          end
`ifdef NF_SUME_RX_LOCK_MONITOR_EN
          else if (!block_lock_s) begin
            if (lol_cnt == ($clog2(LOL_FILTER_LEN))'(LOL_FILTER_LEN - 1)) begin
              state         <= ST_RETRY;
              rxuserrdy     <= 1'b0;
              rx_ready      <= 1'b0;
              gtrxreset_req <= retry_ok;
              pulse_cnt     <= PULSE_LOAD;
              lol_cnt       <= '0;
              if (retry_ok) retry_cnt <= retry_cnt + 1'b1;
            end else begin
              lol_cnt <= lol_cnt + 1'b1;
            end
          end else begin
            lol_cnt <= '0;
          end
`endif
        end

        ST_RETRY: begin
          if (!gtrxreset_req) begin
            state   <= ST_FAIL;
            rx_fail <= 1'b1;
          end else if (pulse_cnt == '0) begin
            state         <= ST_IDLE;
            gtrxreset_req <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end

        ST_FAIL: begin
          rx_fail <= 1'b1;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nf_sume_10g_rx_userrdy_seq.sv
// tb/tb_nf_sume_10g_rx_userrdy_seq.sv - directed self-checking bench for the RX user-ready sequencer
module tb_nf_sume_10g_rx_userrdy_seq;

  logic       txusrclk2 = 1'b0;
  logic       gttxreset;
  logic       qplllock;
  logic       gtrxreset;
  logic       rx_resetdone;
  logic       block_lock;
  logic       rxuserrdy;
  logic       gtrxreset_req;
  logic       rx_ready;
  logic [1:0] retry_cnt;
  logic       rx_fail;

  int vectors     = 0;
  int miscompares = 0;
  int width;
  int seen_req;
  int guard;

  always #5 txusrclk2 = ~txusrclk2;

  nf_sume_10g_rx_userrdy_seq #(
    .SYNC_STAGES       (4),
    .RESETDONE_TIMEOUT (64),
    .LOCK_TIMEOUT      (300),
    .RETRY_PULSE       (8),
    .MAX_RETRIES       (3)
  ) dut (
    .txusrclk2     (txusrclk2),
    .gttxreset     (gttxreset),
    .qplllock      (qplllock),
    .gtrxreset     (gtrxreset),
    .rx_resetdone  (rx_resetdone),
    .block_lock    (block_lock),
    .rxuserrdy     (rxuserrdy),
    .gtrxreset_req (gtrxreset_req),
    .rx_ready      (rx_ready),
    .retry_cnt     (retry_cnt),
    .rx_fail       (rx_fail)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge txusrclk2);
  endtask

  task automatic measure_pulse(output int w);
    w = 0;
    while (gtrxreset_req === 1'b1 && w < 50) begin
      w++;
      cyc(1);
    end
  endtask

  initial begin
    gttxreset = 1'b1; qplllock = 1'b0; gtrxreset = 1'b0;
    rx_resetdone = 1'b0; block_lock = 1'b0;
    cyc(3);
    chk("rst_rxuserrdy", rxuserrdy, 0);
    chk("rst_req", gtrxreset_req, 0);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_retry_cnt", retry_cnt, 0);
    chk("rst_rx_fail", rx_fail, 0);
    gttxreset = 1'b0;
    cyc(1);
    chk("release_rxuserrdy", rxuserrdy, 0);
    chk("release_rx_fail", rx_fail, 0);
    cyc(2);

    // Normal bring-up: rxuserrdy on the 5th edge after qplllock rises
    qplllock = 1'b1;
    cyc(4);
    chk("bringup_rxuserrdy_early", rxuserrdy, 0);
    cyc(1);
    chk("bringup_rxuserrdy", rxuserrdy, 1);
    cyc(35);
    rx_resetdone = 1'b1;
    cyc(200);
    block_lock = 1'b1;
    cyc(4);
    chk("bringup_ready_early", rx_ready, 0);
    cyc(1);
    chk("bringup_rx_ready", rx_ready, 1);
    chk("bringup_rxuserrdy_held", rxuserrdy, 1);
    chk("bringup_retry_cnt", retry_cnt, 0);
    chk("bringup_no_req", gtrxreset_req, 0);

    // qplllock loss in READY, then relock
    cyc(5);
    qplllock = 1'b0;
    cyc(1);
    chk("qpll_drop_rxuserrdy", rxuserrdy, 0);
    chk("qpll_drop_rx_ready", rx_ready, 0);
    chk("qpll_drop_retry_cnt", retry_cnt, 0);
    cyc(3);
    qplllock = 1'b1;
    cyc(4);
    chk("relock_rxuserrdy_early", rxuserrdy, 0);
    cyc(1);
    chk("relock_rxuserrdy", rxuserrdy, 1);
    cyc(1);
    chk("relock_ready_early", rx_ready, 0);
    cyc(1);
    chk("relock_rx_ready", rx_ready, 1);

`ifdef NF_SUME_RX_LOCK_MONITOR_EN
    cyc(5);
    block_lock = 1'b0;
    cyc(10);
    block_lock = 1'b1;
    cyc(20);
    chk("lol_short_rx_ready", rx_ready, 1);
    chk("lol_short_no_req", gtrxreset_req, 0);
    block_lock = 1'b0;
    cyc(19);
    chk("lol_long_req_early", gtrxreset_req, 0);
    cyc(1);
    chk("lol_long_req", gtrxreset_req, 1);
    chk("lol_long_retry_cnt", retry_cnt, 1);
    chk("lol_long_rx_ready", rx_ready, 0);
    block_lock = 1'b1;
    guard = 0;
    while (rx_ready !== 1'b1 && guard < 100) begin
      guard++;
      cyc(1);
    end
    chk("lol_recover_rx_ready", rx_ready, 1);
    chk("lol_recover_retry_cnt", retry_cnt, 0);
`endif

    // Abort and lock timeout on the same edge: abort wins
    cyc(5);
    block_lock = 1'b0;
    qplllock = 1'b0;
    cyc(3);
    qplllock = 1'b1;
    cyc(306);
    chk("abort_pre_rxuserrdy", rxuserrdy, 1);
    chk("abort_pre_req", gtrxreset_req, 0);
    gtrxreset = 1'b1;
    cyc(1);
    chk("abort_rxuserrdy", rxuserrdy, 0);
    chk("abort_no_req", gtrxreset_req, 0);
    chk("abort_retry_cnt", retry_cnt, 0);
    cyc(10);
    chk("abort_no_req_later", gtrxreset_req, 0);

    // rx_resetdone never arrives: three retries then FAIL
    rx_resetdone = 1'b0;
    cyc(2);
    gtrxreset = 1'b0;
    cyc(69);
    chk("timeout_req_early", gtrxreset_req, 0);
    chk("timeout_rxuserrdy_early", rxuserrdy, 1);
    cyc(1);
    chk("timeout1_req", gtrxreset_req, 1);
    chk("timeout1_retry_cnt", retry_cnt, 1);
    chk("timeout1_rxuserrdy", rxuserrdy, 0);
    measure_pulse(width);
    chk("pulse1_width", width, 8);
    for (int n = 2; n <= 3; n++) begin
      guard = 0;
      while (gtrxreset_req !== 1'b1 && guard < 200) begin
        guard++;
        cyc(1);
      end
      chk($sformatf("timeout%0d_retry_cnt", n), retry_cnt, n);
      measure_pulse(width);
      chk($sformatf("pulse%0d_width", n), width, 8);
    end
    seen_req = 0;
    guard = 0;
    while (rx_fail !== 1'b1 && guard < 200) begin
      if (gtrxreset_req === 1'b1) seen_req = 1;
      guard++;
      cyc(1);
    end
    chk("fail_rx_fail", rx_fail, 1);
    chk("fail_no_fourth_pulse", seen_req, 0);
    chk("fail_retry_cnt", retry_cnt, 3);
    chk("fail_rxuserrdy", rxuserrdy, 0);
    chk("fail_rx_ready", rx_ready, 0);
    cyc(20);
    chk("fail_sticky", rx_fail, 1);

    // gttxreset out of FAIL, then clean bring-up
    rx_resetdone = 1'b1;
    block_lock = 1'b1;
    cyc(3);
    gttxreset = 1'b1;
    #1;
    chk("fail_rst_rx_fail", rx_fail, 0);
    chk("fail_rst_retry_cnt", retry_cnt, 0);
    chk("fail_rst_rxuserrdy", rxuserrdy, 0);
    chk("fail_rst_req", gtrxreset_req, 0);
    cyc(2);
    gttxreset = 1'b0;
    cyc(4);
    chk("rebring_rxuserrdy_early", rxuserrdy, 0);
    cyc(1);
    chk("rebring_rxuserrdy", rxuserrdy, 1);
    cyc(2);
    chk("rebring_rx_ready", rx_ready, 1);
    chk("rebring_retry_cnt", retry_cnt, 0);
    chk("rebring_rx_fail", rx_fail, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
